// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline-control unit for the in-order MIPS pipeline.
// Tracks in-flight destinations for STAGES post-decode stages. It generates the
// load-use stall, the IF flush on redirect, the global freeze on cache miss,
// per-operand forwarding selects, halt drain, and stall/freeze counters.
`timescale 1ns/1ps
module pipe_hazard_ctrl #(
  parameter int unsigned STAGES         = 3,
  parameter int unsigned REG_W          = 5,
  parameter int unsigned NUM_SRC        = 2,
  parameter int unsigned LOAD_FWD_STAGE = 1,
  parameter int unsigned COUNT_W        = 32,
  localparam int unsigned FWD_W         = $clog2(STAGES + 1)
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       id_valid,
  input  logic [NUM_SRC*REG_W-1:0]   id_src_num,
  input  logic [NUM_SRC-1:0]         id_src_used,
  input  logic [REG_W-1:0]           id_dst_num,
  input  logic                       id_dst_we,
  input  logic                       id_is_load,
  input  logic                       id_halt,
  input  logic                       id_redirect,
  input  logic                       mem_hit,
  output logic                       freeze,
  output logic                       stall_id,
  output logic                       flush_if,
  output logic [NUM_SRC*FWD_W-1:0]   fwd_sel,
  output logic                       halted,
  output logic [COUNT_W-1:0]         stall_cycles,
  output logic [COUNT_W-1:0]         freeze_cycles
);

  localparam int unsigned DRAIN_W = $clog2(STAGES + 1);

  // In-flight entries: index 0 = EXE, 1 = MEM, 2 = WB, ...
  logic [STAGES-1:0] ent_valid;
  logic [STAGES-1:0] ent_we;
  logic [STAGES-1:0] ent_load;
  logic [REG_W-1:0]  ent_dst [STAGES];

  logic               halt_pend;
  logic [DRAIN_W-1:0] drain;
  logic               raw_stall;
  logic               issue;
  logic [REG_W-1:0]   src;
  logic               found;

  // Hazard search: youngest matching producer wins; loads too young to forward stall.
  always_comb begin
    raw_stall = 1'b0;
    fwd_sel   = '0;
    src       = '0;
    found     = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      src   = id_src_num[i*REG_W +: REG_W];
      found = 1'b0;
      if (id_src_used[i] && (src != '0)) begin
        for (int k = 0; k < int'(STAGES); k++) begin
          if (!found && ent_valid[k] && ent_we[k] && (ent_dst[k] == src)) begin
            found = 1'b1;
            // Select is still driven while stalling so the output stays deterministic.
            fwd_sel[i*FWD_W +: FWD_W] = FWD_W'(k + 1);
            if (ent_load[k] && (k < int'(LOAD_FWD_STAGE))) begin
              raw_stall = 1'b1;
            end
          end
        end
      end
    end
  end

  // Top-level control outputs derived from the hazard search and halt state.
  always_comb begin
    freeze   = ~mem_hit;
    stall_id = (id_valid & raw_stall) | halt_pend | halted;
    flush_if = id_redirect & id_valid & ~stall_id & ~freeze;
    issue    = id_valid & ~stall_id;
  end

  // Advance the tracked entries on every unfrozen edge; stalls inject a bubble.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      ent_valid <= '0;
      ent_we    <= '0;
      ent_load  <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        ent_dst[k] <= '0;
      end
    end else if (!freeze) begin
      for (int k = int'(STAGES) - 1; k > 0; k--) begin
        ent_valid[k] <= ent_valid[k-1];
        ent_we[k]    <= ent_we[k-1];
        ent_load[k]  <= ent_load[k-1];
        ent_dst[k]   <= ent_dst[k-1];
      end
      // The halt instruction travels as a non-writing bubble.
      ent_valid[0] <= issue;
      ent_we[0]    <= issue & id_dst_we & ~id_halt;
      ent_load[0]  <= issue & id_is_load & ~id_halt;
      ent_dst[0]   <= id_dst_num;
    end
  end

  // Halt drain: wait STAGES unfrozen cycles after the halt issues, then latch halted.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      halt_pend <= 1'b0;
      drain     <= '0;
      halted    <= 1'b0;
    end else if (!freeze) begin
      if (halt_pend) begin
        if (drain > DRAIN_W'(1)) begin
          drain <= drain - DRAIN_W'(1);
        end else begin
          drain     <= '0;
          halt_pend <= 1'b0;
          halted    <= 1'b1;
        end
      end else if (issue && id_halt) begin
        halt_pend <= 1'b1;
        drain     <= DRAIN_W'(STAGES);
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      stall_cycles  <= '0;
      freeze_cycles <= '0;
    end else begin
      if (freeze) begin
        if (freeze_cycles != '1) freeze_cycles <= freeze_cycles + COUNT_W'(1);
      end else if (stall_id) begin
        if (stall_cycles != '1) stall_cycles <= stall_cycles + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a driver issues directed then random
// instructions, a reference model predicts each cycle's outputs into a queue,
// and a monitor pops and compares on the falling edge.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

  localparam int STAGES  = 3;
  localparam int REG_W   = 5;
  localparam int NUM_SRC = 2;
  localparam int LFS     = 1;
  localparam int COUNT_W = 32;
  localparam int FWD_W   = 2;
  localparam longint SAT = (longint'(1) << COUNT_W) - 1;

  logic                     clk;
  logic                     rst_b;
  logic                     id_valid;
  logic [NUM_SRC*REG_W-1:0] id_src_num;
  logic [NUM_SRC-1:0]       id_src_used;
  logic [REG_W-1:0]         id_dst_num;
  logic                     id_dst_we;
  logic                     id_is_load;
  logic                     id_halt;
  logic                     id_redirect;
  logic                     mem_hit;
  logic                     freeze;
  logic                     stall_id;
  logic                     flush_if;
  logic [NUM_SRC*FWD_W-1:0] fwd_sel;
  logic                     halted;
  logic [COUNT_W-1:0]       stall_cycles;
  logic [COUNT_W-1:0]       freeze_cycles;

  pipe_hazard_ctrl #(
    .STAGES(STAGES), .REG_W(REG_W), .NUM_SRC(NUM_SRC),
    .LOAD_FWD_STAGE(LFS), .COUNT_W(COUNT_W)
  ) dut (
    .clk(clk), .rst_b(rst_b), .id_valid(id_valid), .id_src_num(id_src_num),
    .id_src_used(id_src_used), .id_dst_num(id_dst_num), .id_dst_we(id_dst_we),
    .id_is_load(id_is_load), .id_halt(id_halt), .id_redirect(id_redirect),
    .mem_hit(mem_hit), .freeze(freeze), .stall_id(stall_id), .flush_if(flush_if),
    .fwd_sel(fwd_sel), .halted(halted), .stall_cycles(stall_cycles),
    .freeze_cycles(freeze_cycles)
  );

  typedef struct {
    bit rst; bit valid; int s0; int s1; bit u0; bit u1;
    int dst; bit we; bit ld; bit halt; bit redir; bit hit;
  } stim_t;

  typedef struct {
    bit freeze; bit stall; bit flush; bit halted;
    bit check_fwd; logic [NUM_SRC*FWD_W-1:0] fwd;
    longint sc; longint fc; int cyc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model: list of in-flight producers, youngest first.
  bit     m_v  [STAGES];
  bit     m_we [STAGES];
  bit     m_ld [STAGES];
  int     m_dst[STAGES];
  int     m_drain_left;
  bit     m_halted;
  longint m_sc, m_fc;

  initial clk = 1'b1;
  always #5 clk = ~clk;

  function automatic longint sat(input longint v);
    return (v > SAT) ? SAT : v;
  endfunction

  function automatic stim_t instr(input int dst, input bit we, input bit ld,
                                  input int s0, input bit u0, input int s1, input bit u1);
    stim_t s;
    s.rst = 0; s.valid = 1; s.s0 = s0; s.s1 = s1; s.u0 = u0; s.u1 = u1;
    s.dst = dst; s.we = we; s.ld = ld; s.halt = 0; s.redir = 0; s.hit = 1;
    return s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < STAGES; k++) begin
      m_v[k] = 0; m_we[k] = 0; m_ld[k] = 0; m_dst[k] = 0;
    end
    m_drain_left = 0; m_halted = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic chk(input string nm, input int c, input longint act, input longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", nm, c, act, want);
    end
  endtask

  // Apply one cycle of stimulus, predict the outputs, then step the model.
  task automatic drive(input stim_t s);
    exp_t e;
    bit raw;
    bit issue;
    int srcs[NUM_SRC];
    bit used[NUM_SRC];
    rst_b       = s.rst;
    id_valid    = s.valid;
    id_src_num  = {REG_W'(s.s1), REG_W'(s.s0)};
    id_src_used = {s.u1, s.u0};
    id_dst_num  = REG_W'(s.dst);
    id_dst_we   = s.we;
    id_is_load  = s.ld;
    id_halt     = s.halt;
    id_redirect = s.redir;
    mem_hit     = s.hit;
    if (s.rst) model_reset();
    srcs[0] = s.s0; srcs[1] = s.s1; used[0] = s.u0; used[1] = s.u1;
    raw = 0;
    e.fwd = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (used[i] && srcs[i] != 0) begin
        for (int k = 0; k < STAGES; k++) begin
          if (m_v[k] && m_we[k] && m_dst[k] == srcs[i]) begin
            if (m_ld[k] && k < LFS) raw = 1;
            e.fwd[i*FWD_W +: FWD_W] = FWD_W'(k + 1);
            break;
          end
        end
      end
    end
    e.freeze    = !s.hit;
    e.stall     = (s.valid && raw) || (m_drain_left > 0) || m_halted;
    e.flush     = s.redir && s.valid && !e.stall && !e.freeze;
    e.check_fwd = !e.stall;
    e.halted    = m_halted;
    e.sc        = m_sc;
    e.fc        = m_fc;
    e.cyc       = cyc;
    sb.push_back(e);
    if (!s.rst) begin
      if (!s.hit) begin
        m_fc = sat(m_fc + 1);
      end else begin
        issue = s.valid && !e.stall;
        if (e.stall) m_sc = sat(m_sc + 1);
        for (int k = STAGES - 1; k > 0; k--) begin
          m_v[k] = m_v[k-1]; m_we[k] = m_we[k-1]; m_ld[k] = m_ld[k-1]; m_dst[k] = m_dst[k-1];
        end
        m_v[0]   = issue;
        m_we[0]  = issue && s.we && !s.halt;
        m_ld[0]  = issue && s.ld && !s.halt;
        m_dst[0] = s.dst;
        if (m_drain_left > 0) begin
          m_drain_left--;
          if (m_drain_left == 0) m_halted = 1;
        end else if (issue && s.halt) begin
          m_drain_left = STAGES;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Monitor: compare the oldest prediction against what the DUT shows mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("freeze", e.cyc, longint'(freeze), longint'(e.freeze));
        chk("stall_id", e.cyc, longint'(stall_id), longint'(e.stall));
        chk("flush_if", e.cyc, longint'(flush_if), longint'(e.flush));
        chk("halted", e.cyc, longint'(halted), longint'(e.halted));
        chk("stall_cycles", e.cyc, longint'(stall_cycles), e.sc);
        chk("freeze_cycles", e.cyc, longint'(freeze_cycles), e.fc);
        if (e.check_fwd) chk("fwd_sel", e.cyc, longint'(fwd_sel), longint'(e.fwd));
      end
    end
  end

  initial begin
    stim_t s;
    stim_t nop;
    model_reset();
    #1;
    nop = instr(9, 0, 0, 0, 0, 0, 0);
    // Reset with a redirect present.
    s = nop; s.rst = 1; s.redir = 1; drive(s);
    s = nop; s.rst = 1; drive(s);
    // ADD r3, then two readers of r3 (fwd 1 then 2).
    drive(instr(3, 1, 0, 0, 0, 0, 0));
    drive(instr(7, 1, 0, 3, 1, 0, 0));
    drive(instr(8, 1, 0, 3, 1, 0, 0));
    // LW r5 then a user: one stall cycle, then forward from MEM.
    drive(instr(5, 1, 1, 0, 0, 0, 0));
    drive(instr(10, 1, 0, 1, 0, 5, 1));
    drive(instr(10, 1, 0, 1, 0, 5, 1));
    // ADD r0 then reader of r0.
    drive(instr(0, 1, 0, 0, 0, 0, 0));
    drive(instr(11, 1, 0, 0, 1, 0, 1));
    // Load-use stall together with a redirect.
    drive(instr(6, 1, 1, 0, 0, 0, 0));
    s = instr(12, 1, 0, 6, 1, 0, 0); s.redir = 1;
    drive(s); drive(s);
    drive(nop);
    // Four frozen cycles during a load-use stall.
    drive(instr(4, 1, 1, 0, 0, 0, 0));
    s = instr(13, 1, 0, 4, 1, 4, 1); s.hit = 0;
    repeat (4) drive(s);
    s.hit = 1;
    drive(s); drive(s);
    // Halt, reset mid-drain, then a full halt drain.
    s = nop; s.halt = 1; drive(s);
    drive(nop); drive(nop);
    s = nop; s.rst = 1; drive(s);
    s = nop; s.halt = 1; drive(s);
    repeat (5) drive(nop);
    s = nop; s.rst = 1; drive(s);
    // Random traffic over a small register window to force frequent hazards.
    for (int n = 0; n < 3000; n++) begin
      s.rst   = m_halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 199) == 0);
      s.valid = ($urandom_range(0, 9) != 0);
      s.s0    = $urandom_range(0, 3);
      s.s1    = $urandom_range(0, 3);
      s.u0    = $urandom_range(0, 1);
      s.u1    = $urandom_range(0, 1);
      s.dst   = $urandom_range(0, 3);
      s.we    = ($urandom_range(0, 4) != 0);
      s.ld    = ($urandom_range(0, 9) < 3);
      s.halt  = ($urandom_range(0, 49) == 0);
      s.redir = ($urandom_range(0, 4) == 0);
      s.hit   = ($urandom_range(0, 6) != 0);
      drive(s);
    end
    s = nop;
    drive(s);
    repeat (3) @(posedge clk);
    if (sb.size() != 0) chk("scoreboard_drain", cyc, longint'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
